// File: rtl/mem_data_controller.sv
// MEM-stage data memory controller: req/ack handshake, big-endian lane steering, load extension.
// Optional LL/SC link tracking is compiled in when the LLSC_EN macro is defined.
module mem_data_controller #(
    parameter int ADDR_WIDTH = 30
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  Pipe_Stall,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  MemByte,
    input  logic                  MemHalf,
    input  logic                  MemSignExtnd,
    input  logic                  LLSC,
    input  logic                  LLSC_Clear,
    input  logic [31:0]           Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  M_Stall_Controller,
    output logic                  Exc_AdEL,
    output logic                  Exc_AdES,
    input  logic [31:0]           DataMem_In,
    input  logic                  DataMem_Ack,
    output logic                  DataMem_Read,
    output logic [3:0]            DataMem_Write,
    output logic [ADDR_WIDTH-1:0] DataMem_Address,
    output logic [31:0]           DataMem_Out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        read_reg;
    logic [3:0]  write_reg;
    logic [31:0] result_reg;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        is_sc;
    logic        sc_fail;
    logic        access;
    logic        ack_done;
    logic [3:0]  lane_en;
    logic [7:0]  rd_byte [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [29:0] word_addr;

    assign word_addr  = Address[31:2];
    assign is_byte    = MemByte;
    assign is_half    = MemHalf & ~MemByte;
    assign is_word    = ~MemByte & ~MemHalf;
    assign misaligned = (is_half & Address[0]) | (is_word & (Address[1:0] != 2'b00));

    assign Exc_AdEL = MemRead & misaligned;
    assign Exc_AdES = MemWrite & misaligned;

    assign is_sc    = MemWrite & LLSC;
    assign access   = (MemRead | MemWrite) & ~misaligned & ~sc_fail;
    assign ack_done = (state_reg == ST_REQ) & DataMem_Ack;

    // Stall is combinational so the hazard unit sees it in the detect cycle.
    assign M_Stall_Controller = access & (state_reg != ST_DONE);

`ifdef LLSC_EN
    logic        link_reg;
    logic [29:0] link_addr_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            link_reg      <= 1'b0;
            link_addr_reg <= '0;
        end else if (LLSC_Clear) begin
            link_reg <= 1'b0;
        end else if (ack_done) begin
            if (MemRead && LLSC) begin
                link_reg      <= 1'b1;
                link_addr_reg <= word_addr;
            end else if (MemWrite && link_reg && (link_addr_reg == word_addr)) begin
                link_reg <= 1'b0;
            end
        end
    end

    // Only judged in IDLE: a successful SC clears the link itself and must not fail afterwards.
    assign sc_fail = is_sc & (state_reg == ST_IDLE) &
                     ~(link_reg & (link_addr_reg == word_addr));
`else
    logic unused_llsc_clear;

    assign sc_fail           = 1'b0;
    assign unused_llsc_clear = LLSC_Clear;
`endif

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (access)      state_next = ST_REQ;
            ST_REQ:  if (DataMem_Ack) state_next = ST_DONE;
            ST_DONE: if (!Pipe_Stall) state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        lane_en = 4'b1111;
        if (is_byte) begin
            lane_en = 4'b1000 >> Address[1:0];
        end else if (is_half) begin
            lane_en = Address[1] ? 4'b0011 : 4'b1100;
        end
    end

    // Byte lane gi is the gi-th byte in big-endian order; store data is replicated per size.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_byte[gi] = DataMem_In[31-8*gi -: 8];
        assign DataMem_Out[8*gi +: 8] = is_byte ? DataIn[7:0] :
                                        is_half ? DataIn[8*(gi%2) +: 8] :
                                                  DataIn[8*gi +: 8];
    end

    always_comb begin
        ld_byte = rd_byte[Address[1:0]];
        ld_half = {rd_byte[{Address[1], 1'b0}], rd_byte[{Address[1], 1'b1}]};
        if (is_byte) begin
            load_data = {{24{MemSignExtnd & ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            load_data = {{16{MemSignExtnd & ld_half[15]}}, ld_half};
        end else begin
            load_data = DataMem_In;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            read_reg   <= 1'b0;
            write_reg  <= 4'b0000;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && access) begin
                read_reg  <= MemRead;
                write_reg <= MemWrite ? lane_en : 4'b0000;
            end else if (ack_done) begin
                read_reg  <= 1'b0;
                write_reg <= 4'b0000;
            end
            // Plain stores leave the previous load result in place.
            if (ack_done) begin
                if (MemRead) begin
                    result_reg <= load_data;
                end else if (is_sc) begin
                    result_reg <= 32'd1;
                end
            end
        end
    end

    assign DataMem_Read    = read_reg;
    assign DataMem_Write   = write_reg;
    assign DataMem_Address = Address[ADDR_WIDTH+1:2];
    assign DataOut         = sc_fail ? 32'd0 : result_reg;

endmodule

// File: tb/tb_mem_data_controller.sv
// Self-checking bench for mem_data_controller: behavioural model + per-cycle compare process.
// LL/SC link checks are included when LLSC_EN is defined.
module tb_mem_data_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_stall = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        mem_byte = 1'b0;
    logic        mem_half = 1'b0;
    logic        mem_sx = 1'b0;
    logic        llsc = 1'b0;
    logic        llsc_clear = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_mem_in = '0;
    logic        data_mem_ack = 1'b0;

    logic [31:0] DataOut;
    logic        M_Stall_Controller;
    logic        Exc_AdEL;
    logic        Exc_AdES;
    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out;

    mem_data_controller #(.ADDR_WIDTH(30)) dut (
        .clock              (clk),
        .reset_n            (rst_n),
        .Pipe_Stall         (pipe_stall),
        .MemRead            (mem_read),
        .MemWrite           (mem_write),
        .MemByte            (mem_byte),
        .MemHalf            (mem_half),
        .MemSignExtnd       (mem_sx),
        .LLSC               (llsc),
        .LLSC_Clear         (llsc_clear),
        .Address            (address),
        .DataIn             (data_in),
        .DataOut            (DataOut),
        .M_Stall_Controller (M_Stall_Controller),
        .Exc_AdEL           (Exc_AdEL),
        .Exc_AdES           (Exc_AdES),
        .DataMem_In         (data_mem_in),
        .DataMem_Ack        (data_mem_ack),
        .DataMem_Read       (DataMem_Read),
        .DataMem_Write      (DataMem_Write),
        .DataMem_Address    (DataMem_Address),
        .DataMem_Out        (DataMem_Out)
    );

    always #5 clk = ~clk;

    // Expectations published by the driver, consumed at the falling edge.
    logic        chk = 1'b0;
    logic        txn_start = 1'b0;
    logic        txn_end = 1'b0;
    int          phase = 3;
    logic        e_stall = 1'b0;
    logic        e_read = 1'b0;
    logic        e_adel = 1'b0;
    logic        e_ades = 1'b0;
    logic [3:0]  e_write = '0;
    logic [31:0] e_dout = '0;
    logic [31:0] e_mout = '0;
    logic [29:0] e_maddr = '0;
    int          e_starts = 0;
    int          e_slen = 0;

    logic        lit_on = 1'b0;
    logic        lit_wr_on = 1'b0;
    logic [1:0]  lit_exc = '0;
    logic [29:0] lit_maddr = '0;
    logic [3:0]  lit_write = '0;
    logic [31:0] lit_mout = '0;
    logic [31:0] lit_dout = '0;
    int          lit_slen = 0;
    int          lit_starts = 0;

    int          total = 0;
    int          bad = 0;
    int          starts = 0;
    int          slen = 0;
    logic        prev_req = 1'b0;

    // Model state
    logic [31:0] m_result = '0;
`ifdef LLSC_EN
    logic        m_link = 1'b0;
    logic [29:0] m_link_addr = '0;
`endif

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            if (txn_start) begin
                starts = 0;
                slen   = 0;
            end
            if (M_Stall_Controller) slen++;
            if ((DataMem_Read || (DataMem_Write != 4'b0)) && !prev_req) starts++;
            cmp("stall", {31'd0, M_Stall_Controller}, {31'd0, e_stall});
            cmp("read_req", {31'd0, DataMem_Read}, {31'd0, e_read});
            cmp("write_lanes", {28'd0, DataMem_Write}, {28'd0, e_write});
            cmp("exc_adel", {31'd0, Exc_AdEL}, {31'd0, e_adel});
            cmp("exc_ades", {31'd0, Exc_AdES}, {31'd0, e_ades});
            cmp("data_out", DataOut, e_dout);
            if (e_read || (e_write != 4'b0)) cmp("mem_addr", {2'b0, DataMem_Address}, {2'b0, e_maddr});
            if (e_write != 4'b0) cmp("mem_out", DataMem_Out, e_mout);
            if (txn_end) begin
                cmp("req_count", starts, e_starts);
                cmp("stall_len", slen, e_slen);
            end
            if (lit_on) begin
                if (phase == 0) cmp("lit_exc", {30'd0, Exc_AdEL, Exc_AdES}, {30'd0, lit_exc});
                if (phase == 1) begin
                    cmp("lit_addr", {2'b0, DataMem_Address}, {2'b0, lit_maddr});
                    if (lit_wr_on) begin
                        cmp("lit_lanes", {28'd0, DataMem_Write}, {28'd0, lit_write});
                        cmp("lit_mout", DataMem_Out, lit_mout);
                    end
                end
                if (txn_end) begin
                    cmp("lit_dout", DataOut, lit_dout);
                    cmp("lit_stall_len", slen, lit_slen);
                    cmp("lit_req_count", starts, lit_starts);
                end
            end
        end
        prev_req = DataMem_Read || (DataMem_Write != 4'b0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lit(input bit wr_on, input logic [1:0] exc, input logic [29:0] maddr,
                           input logic [3:0] lanes, input logic [31:0] mout,
                           input logic [31:0] dout, input int sl, input int st);
        lit_on = 1'b1;  lit_wr_on = wr_on; lit_exc = exc; lit_maddr = maddr;
        lit_write = lanes; lit_mout = mout; lit_dout = dout; lit_slen = sl; lit_starts = st;
    endtask

    task automatic idle_cycle(input bit clr);
        mem_read = 1'b0; mem_write = 1'b0; llsc = 1'b0; llsc_clear = clr;
        data_mem_ack = ($urandom % 2) == 1;
        phase = 3; e_stall = 1'b0; e_read = 1'b0; e_write = '0;
        e_adel = 1'b0; e_ades = 1'b0; e_dout = m_result;
        step();
        llsc_clear = 1'b0;
        data_mem_ack = 1'b0;
`ifdef LLSC_EN
        if (clr) m_link = 1'b0;
`endif
    endtask

    task automatic run_txn(input bit rd, input bit wr, input bit by, input bit hf,
                           input bit sx, input bit ll, input logic [31:0] addr,
                           input logic [31:0] din, input logic [31:0] memw,
                           input int k, input int hold);
        int          size;
        int          off;
        bit          misal;
        bit          sc;
        bit          fail;
        bit          acc;
        logic [3:0]  lanes;
        logic [31:0] mout;
        logic [31:0] ldval;
        logic [31:0] new_result;
        size  = by ? 1 : (hf ? 2 : 4);
        off   = int'(addr[1:0]);
        misal = (off % size) != 0;
        sc    = wr && ll;
        fail  = 1'b0;
`ifdef LLSC_EN
        fail = sc && !(m_link && (m_link_addr == addr[31:2]));
`endif
        acc = (rd || wr) && !misal && !fail;
        lanes = '0;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + size) lanes[3-i] = 1'b1;
        mout = '0;
        for (int j = 0; j < 4; j++) mout[8*j +: 8] = din[8*(j % size) +: 8];
        ldval = (memw << (8*off)) >> (32 - 8*size);
        if (sx && size < 4 && ldval[8*size-1]) ldval = ldval | (32'hFFFF_FFFF << (8*size));
        new_result = m_result;
        if (acc && rd) new_result = ldval;
        else if (acc && sc) new_result = 32'd1;

        mem_read = rd; mem_write = wr; mem_byte = by; mem_half = hf; mem_sx = sx; llsc = ll;
        address = addr; data_in = din; data_mem_in = memw; data_mem_ack = 1'b0;
        pipe_stall = ($urandom % 2) == 1;
        phase = 0; txn_start = 1'b1; txn_end = !acc;
        e_stall = acc; e_read = 1'b0; e_write = '0;
        e_adel = rd && misal; e_ades = wr && misal;
        e_dout = fail ? 32'd0 : m_result;
        e_maddr = addr[31:2]; e_mout = mout;
        e_starts = acc ? 1 : 0;
        e_slen = acc ? k + 1 : 0;
        step();
        txn_start = 1'b0;
        if (acc) begin
            for (int c = 1; c <= k; c++) begin
                phase = 1; e_read = rd; e_write = wr ? lanes : 4'b0;
                e_adel = 1'b0; e_ades = 1'b0;
                data_mem_ack = (c == k);
                pipe_stall = ($urandom % 2) == 1;
                step();
            end
            m_result = new_result;
`ifdef LLSC_EN
            if (rd && ll) begin
                m_link = 1'b1;
                m_link_addr = addr[31:2];
            end else if (wr && m_link && (m_link_addr == addr[31:2])) begin
                m_link = 1'b0;
            end
`endif
            for (int c = 0; c <= hold; c++) begin
                phase = 2; e_stall = 1'b0; e_read = 1'b0; e_write = '0;
                e_dout = new_result; txn_end = (c == hold);
                pipe_stall = (c < hold);
                data_mem_ack = ($urandom % 3) == 0;
                data_mem_in = $urandom;
                step();
            end
            data_mem_ack = 1'b0;
        end
        txn_end = 1'b0;
        lit_on = 1'b0;
        lit_wr_on = 1'b0;
        $display("txn rd=%0d wr=%0d size=%0d sx=%0d ll=%0d addr=%h din=%h access=%0d k=%0d hold=%0d result=%h",
                 rd, wr, size, sx, ll, addr, din, acc, k, hold, m_result);
    endtask

    task automatic reset_mid_req();
        mem_read = 1'b1; mem_write = 1'b0; mem_byte = 1'b0; mem_half = 1'b0; llsc = 1'b0;
        address = 32'h0000_0400; data_mem_ack = 1'b0;
        phase = 0; e_stall = 1'b1; e_read = 1'b0; e_write = '0; e_adel = 1'b0; e_ades = 1'b0;
        e_dout = m_result; e_maddr = 30'h100;
        step();
        phase = 1; e_read = 1'b1;
        step();
        rst_n = 1'b0;
        m_result = '0;
`ifdef LLSC_EN
        m_link = 1'b0;
`endif
        phase = 3; e_read = 1'b0; e_stall = 1'b1; e_dout = '0;
        step();
        mem_read = 1'b0; e_stall = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        $display("txn reset asserted during request phase");
    endtask

    initial begin
        chk = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();

        set_lit(1'b0, 2'b00, 30'h40, 4'h0, 32'h0, 32'hA1B2_C3D4, 4, 1);
        run_txn(1, 0, 0, 0, 0, 0, 32'h0000_0100, 32'h0, 32'hA1B2_C3D4, 3, 0);
        set_lit(1'b0, 2'b00, 30'h40, 4'h0, 32'h0, 32'hFFFF_FFF0, 2, 1);
        run_txn(1, 0, 1, 0, 1, 0, 32'h0000_0103, 32'h0, 32'h0000_00F0, 1, 0);
        set_lit(1'b0, 2'b00, 30'h40, 4'h0, 32'h0, 32'h0000_00F0, 2, 1);
        run_txn(1, 0, 1, 0, 0, 0, 32'h0000_0103, 32'h0, 32'h0000_00F0, 1, 0);
        set_lit(1'b1, 2'b00, 30'h80, 4'b0011, 32'hABCD_ABCD, 32'h0000_00F0, 3, 1);
        run_txn(0, 1, 0, 1, 0, 0, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 2, 0);
        set_lit(1'b0, 2'b10, 30'h0, 4'h0, 32'h0, 32'h0000_00F0, 0, 0);
        run_txn(1, 0, 0, 0, 0, 0, 32'h0000_0101, 32'h0, 32'h0, 1, 0);
        set_lit(1'b0, 2'b01, 30'h0, 4'h0, 32'h0, 32'h0000_00F0, 0, 0);
        run_txn(0, 1, 0, 1, 0, 0, 32'h0000_0201, 32'h1234_ABCD, 32'h0, 1, 0);
        set_lit(1'b0, 2'b00, 30'h41, 4'h0, 32'h0, 32'h5566_7788, 3, 1);
        run_txn(1, 0, 0, 0, 0, 0, 32'h0000_0104, 32'h0, 32'h5566_7788, 2, 5);
        idle_cycle(1'b0);

`ifdef LLSC_EN
        set_lit(1'b0, 2'b00, 30'hC0, 4'h0, 32'h0, 32'h0BAD_F00D, 2, 1);
        run_txn(1, 0, 0, 0, 0, 1, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 1, 0);
        set_lit(1'b1, 2'b00, 30'hC0, 4'hF, 32'h0000_0077, 32'h0000_0001, 2, 1);
        run_txn(0, 1, 0, 0, 0, 1, 32'h0000_0300, 32'h0000_0077, 32'h0, 1, 0);
        set_lit(1'b0, 2'b00, 30'h0, 4'h0, 32'h0, 32'h0000_0000, 0, 0);
        run_txn(0, 1, 0, 0, 0, 1, 32'h0000_0300, 32'h0000_0055, 32'h0, 1, 0);
        run_txn(1, 0, 0, 0, 0, 1, 32'h0000_0300, 32'h0, 32'h1234_5678, 1, 0);
        idle_cycle(1'b1);
        set_lit(1'b0, 2'b00, 30'h0, 4'h0, 32'h0, 32'h0000_0000, 0, 0);
        run_txn(0, 1, 0, 0, 0, 1, 32'h0000_0300, 32'h0000_0066, 32'h0, 1, 0);
`else
        set_lit(1'b1, 2'b00, 30'hC0, 4'hF, 32'h0000_0077, 32'h0000_0001, 2, 1);
        run_txn(0, 1, 0, 0, 0, 1, 32'h0000_0300, 32'h0000_0077, 32'h0, 1, 0);
`endif

        for (int n = 0; n < 200; n++) begin
            int          op;
            int          sz;
            logic [29:0] word;
            logic [31:0] addr;
            op = int'($urandom % 8);
            if (op == 0) begin
                idle_cycle(($urandom % 2) == 1);
            end else begin
                sz = int'($urandom % 3);
                word = 30'h0C0 + 30'($urandom % 4);
                if ($urandom % 4 == 0) word = 30'($urandom);
                addr = {word, 2'($urandom % 4)};
                run_txn(op <= 4, op > 4, sz == 0, sz == 1, ($urandom % 2) == 1,
                        ($urandom % 3) == 0, addr, $urandom, $urandom,
                        int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
            end
        end

        reset_mid_req();
        set_lit(1'b0, 2'b00, 30'h41, 4'h0, 32'h0, 32'hFFFF_8899, 2, 1);
        run_txn(1, 0, 0, 1, 1, 0, 32'h0000_0106, 32'h0, 32'h1234_8899, 1, 0);

        chk = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
